triggered_capture_buffer: RTL
=============================

// Module: triggered_capture_buffer
// PURPOSE
//  Parametrised pre/post-trigger sample capture between the ADC sample stream and the offload path (UART / SD writer).
//  Continuously records samples into a circular BRAM buffer and freezes a window of PRE_TRIGGER samples before the trigger plus the remainder after it.
//  It then streams the whole DEPTH-sample frame out over a valid/ready stream with a last flag.
//  One-shot or auto-rearm mode.
// PARAMETERS
//  SAMPLE_DATA_WIDTH  8     bits per sample
//  DEPTH              1024  frame length in samples; power of 2, >= 4
//  PRE_TRIGGER        256   samples kept before trigger; 0 <= PRE_TRIGGER < DEPTH
//  AUTO_REARM         1     1: re-enter FILL after each frame; 0: wait in IDLE for arm
//  DROP_CNT_WIDTH     16    width of dropped-sample counter
// PORTS
//  clk            in   1      system clock (sys_clk domain)
//  rst            in   1      synchronous, active-high reset
//  axiiv          in   1      input sample valid (one-cycle strobe per sample)
//  axiid          in   SDW    input sample
//  trigger        in   1      trigger level; its rising edge starts a capture
//  arm            in   1      one-cycle pulse; leaves IDLE (used only when AUTO_REARM=0)
//  axiov          out  1      output beat valid
//  axiod          out  SDW    output sample
//  axiol          out  1      high on last beat of frame
//  axior          in   1      downstream ready
//  state          out  3      0 IDLE, 1 FILL, 2 ARMED, 3 POST, 4 DRAIN
//  dropped_count  out  DCW    input samples discarded during DRAIN/IDLE; saturating
// BEHAVIOUR
//  Reset state:
//  - state=FILL, or ARMED when PRE_TRIGGER=0.
//  - wr_ptr=0, fill/post counters=0, axiov=0, axiod=0, axiol=0, dropped_count=0, trigger_q=0.
//  Edge detect:
//  - trig_edge = trigger & ~trigger_q.
//  - trigger_q updates every cycle in all states, so a level held high across a state change never fires.
//  FILL:
//  - Each axiiv writes axiid at wr_ptr; wr_ptr++ mod DEPTH; fill_cnt++.
//  - When the PRE_TRIGGER-th sample is written, go to ARMED next cycle.
//  - Triggers are ignored.
//  ARMED:
//  - Keep writing the ring (old data overwritten).
//  - On trig_edge: start_ptr = (wr_ptr - PRE_TRIGGER) mod DEPTH; go to POST.
//  - If axiiv is coincident with trig_edge, that sample is the first post-trigger sample (frame index PRE_TRIGGER).
//  POST:
//  - Write samples until DEPTH-PRE_TRIGGER post-trigger samples are stored (including any coincident sample), then go to DRAIN.
//  - Triggers are ignored.
//  DRAIN:
//  - Read DEPTH samples from start_ptr upward, wrapping mod DEPTH. BRAM read latency is 1 cycle.
//  - First axiov no later than 2 cycles after entering DRAIN.
//  - A beat transfers on axiov & axior.
//  - axiod and axiol are held stable while axiov & ~axior.
//  - No duplicated or skipped beats.
//  - axiol is high only on beat DEPTH-1.
//  - Incoming axiiv is not written; each one increments dropped_count, which saturates at all-ones.
//  - After the last beat transfers: axiov=0 next cycle; go to FILL (AUTO_REARM=1) or IDLE (AUTO_REARM=0).
//  - fill_cnt is cleared on this exit.
//  IDLE:
//  - Inputs are discarded and counted as in DRAIN.
//  - An arm pulse goes to FILL, or ARMED if PRE_TRIGGER=0.
//  - arm in any other state is ignored.
//  Entering FILL clears dropped_count.
//  rst at any time, including mid-DRAIN: outputs reach their reset values the next cycle and the frame is abandoned with no axiol.
//  Frame content equals the last PRE_TRIGGER samples before the edge followed by the next DEPTH-PRE_TRIGGER samples, in arrival order.
// TESTING
//  - DEPTH=16, PRE=4, ramp 0,1,2.. on axiiv every 3rd cycle, trigger edge with sample 10, axior=1 -> frame 6..21, axiol on 21.
//  - Same, trigger with sample 40 (ring wrapped) -> frame 36..51; random axior toggling -> identical frame, axiod stable while stalled.
//  - Trigger high from reset through FILL and into ARMED -> no capture; first later rising edge at sample 12 -> frame 8..23.
//  - Trigger pulse during POST and DRAIN -> ignored; exactly one frame of 16 beats.
//  - Hold axior=0 for 50 cycles in DRAIN with axiiv every cycle -> dropped_count=50; DCW=4 with 20 inputs -> 15.
//  - AUTO_REARM=0 -> after frame state=IDLE, inputs ignored; arm -> FILL, dropped_count=0; rst mid-DRAIN -> axiov=0 next cycle, state=FILL.

Source files
------------

// File: rtl/triggered_capture_buffer.sv
// Pre/post-trigger capture of a sample stream into a circular buffer.
// The frozen DEPTH-sample frame is then streamed out over valid/ready with a last flag.
module triggered_capture_buffer #(
  parameter int SAMPLE_DATA_WIDTH = 8,
  parameter int DEPTH             = 1024,
  parameter int PRE_TRIGGER       = 256,
  parameter int AUTO_REARM        = 1,
  parameter int DROP_CNT_WIDTH    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         axiiv,
  input  logic [SAMPLE_DATA_WIDTH-1:0] axiid,
  input  logic                         trigger,
  input  logic                         arm,
  output logic                         axiov,
  output logic [SAMPLE_DATA_WIDTH-1:0] axiod,
  output logic                         axiol,
  input  logic                         axior,
  output logic [2:0]                   state,
  output logic [DROP_CNT_WIDTH-1:0]    dropped_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam state_t START_STATE = (PRE_TRIGGER == 0) ? S_ARMED : S_FILL;
  localparam state_t REARM_STATE = (AUTO_REARM != 0) ? START_STATE : S_IDLE;

  localparam logic [AW-1:0] PRE_PTR   = AW'(PRE_TRIGGER);
  localparam logic [AW-1:0] ONE_PTR   = AW'(1);
  localparam logic [CW-1:0] ONE_CNT   = CW'(1);
  localparam logic [CW-1:0] PRE_CNT   = CW'(PRE_TRIGGER);
  localparam logic [CW-1:0] POST_CNT  = CW'(DEPTH - PRE_TRIGGER);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_CNT  = CW'(DEPTH - 1);

  logic [SAMPLE_DATA_WIDTH-1:0] mem [DEPTH];

  state_t        st;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fill_cnt;
  logic [CW-1:0] post_cnt;
  logic [CW-1:0] rd_cnt;
  logic          trigger_q;
  logic          trig_edge;
  logic          wr_en;
  logic          rd_en;
  logic          drop_en;
  logic          last_xfer;

  assign state     = st;
  assign trig_edge = trigger & ~trigger_q;
  assign wr_en     = axiiv && (st == S_FILL || st == S_ARMED || st == S_POST);
  // The read register doubles as the output register, so a read is only
  // issued when the current beat is empty or leaving this cycle.
  assign rd_en     = (st == S_DRAIN) && (rd_cnt != DEPTH_CNT) && (!axiov || axior);
  assign drop_en   = axiiv && (st == S_IDLE || st == S_DRAIN) && (dropped_count != '1);
  assign last_xfer = axiov && axior && axiol;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= axiid;
  end

  always_ff @(posedge clk) begin
    if (rst)        axiod <= '0;
    else if (rd_en) axiod <= mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= START_STATE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fill_cnt      <= '0;
      post_cnt      <= '0;
      rd_cnt        <= '0;
      axiov         <= 1'b0;
      axiol         <= 1'b0;
      dropped_count <= '0;
      trigger_q     <= 1'b0;
    end else begin
      trigger_q <= trigger;
      if (wr_en)   wr_ptr <= wr_ptr + ONE_PTR;
      if (drop_en) dropped_count <= dropped_count + 1'b1;

      case (st)
        S_IDLE: begin
          if (arm) begin
            st            <= START_STATE;
            fill_cnt      <= '0;
            dropped_count <= '0;
          end
        end
        S_FILL: begin
          if (axiiv) begin
            fill_cnt <= fill_cnt + ONE_CNT;
            if (fill_cnt + ONE_CNT == PRE_CNT) st <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (trig_edge) begin
            // wr_ptr has not yet advanced past a coincident sample, so that
            // sample lands at frame index PRE_TRIGGER.
            rd_ptr   <= wr_ptr - PRE_PTR;
            rd_cnt   <= '0;
            post_cnt <= {{(CW-1){1'b0}}, axiiv};
            if (axiiv && POST_CNT == ONE_CNT) st <= S_DRAIN;
            else                              st <= S_POST;
          end
        end
        S_POST: begin
          if (axiiv) begin
            post_cnt <= post_cnt + ONE_CNT;
            if (post_cnt + ONE_CNT == POST_CNT) st <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (rd_en) begin
            axiov  <= 1'b1;
            axiol  <= (rd_cnt == LAST_CNT);
            rd_ptr <= rd_ptr + ONE_PTR;
            rd_cnt <= rd_cnt + ONE_CNT;
          end else if (axiov && axior) begin
            axiov <= 1'b0;
            axiol <= 1'b0;
          end
          if (last_xfer) begin
            st       <= REARM_STATE;
            fill_cnt <= '0;
            if (REARM_STATE != S_IDLE) dropped_count <= '0;
          end
        end
        default: st <= START_STATE;
      endcase
    end
  end

endmodule
